framebuffer_spram_arbiter: RTL and testbench
============================================

FRAMEBUFFER_SPRAM_ARBITER -- requirements
Module: framebuffer_spram_arbiter

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 14, meaning framebuffer word address width.
REQ-002 SHALL have parameter WBUF_DEPTH, default 2, meaning write-buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have ports rd_req input 1, rd_index input INDEX_WIDTH, rd_grant output 1  pipeline read request; consumed only in a cycle with rd_grant=1.
REQ-006 SHALL have ports rd_valid output 1, rd_data output 16  read return.
REQ-007 SHALL have ports wr_req input 1, wr_index input INDEX_WIDTH, wr_data input 16, wr_ready output 1  pipeline write; accepted when wr_req & wr_ready.
REQ-008 SHALL have ports clear_start input 1, clear_value input 16, clear_busy output 1  framebuffer clear command.
REQ-009 SHALL have ports mem_addr output INDEX_WIDTH, mem_wdata output 16, mem_we output 1, mem_rdata input 16  single-port RAM, 1-cycle read latency.

Function
REQ-010 SHALL issue at most one memory access (read or write) per cycle.
REQ-011 SHALL hold accepted writes in an in-order FIFO of WBUF_DEPTH entries; wr_ready = not full (registered occupancy).
REQ-012 SHALL permit enqueue and drain in the same cycle; occupancy then unchanged.
REQ-013 Priority per cycle when not clearing: (1) drain if FIFO full; (2) drain if rd_req and rd_index equals any buffered entry index (RAW hazard); (3) grant read if rd_req; (4) drain if FIFO non-empty; (5) idle.
REQ-014 rd_grant SHALL be combinational and high only in cycles where case (3) is selected.
REQ-015 rd_valid SHALL be high exactly one cycle after each grant, with rd_data = mem_rdata.
REQ-016 A read and a write to the same index enqueued in the same cycle SHALL return the pre-write data.
REQ-017 A drain SHALL drive mem_we=1, mem_addr/mem_wdata from FIFO head; mem_we=0 otherwise.
REQ-018 Clear FSM states IDLE, DRAIN, CLEAR; IDLE->DRAIN on clear_start, DRAIN->CLEAR when FIFO empty, CLEAR->IDLE after last address.
REQ-019 In DRAIN, FIFO SHALL drain one entry per cycle; rd_grant=0, wr_ready=0.
REQ-020 In CLEAR, SHALL write clear_value (latched at clear_start) to addresses 0 .. 2^INDEX_WIDTH-1 ascending, one per cycle, counter INDEX_WIDTH+1 bits; rd_grant=0, wr_ready=0.
REQ-021 clear_busy SHALL be 1 in DRAIN and CLEAR, 0 in IDLE; clear_start while busy SHALL be ignored.
REQ-022 Clear of empty FIFO SHALL take exactly 1 DRAIN cycle + 2^INDEX_WIDTH CLEAR cycles.

Reset
REQ-023 On reset=0: FIFO empty, pointers 0, FSM IDLE, clear counter 0, rd_valid=0, mem_we=0, clear_busy=0, rd_grant=0, wr_ready=0 until the first clock after release.
REQ-024 Reset mid-clear or with buffered writes SHALL discard all pending work; no write SHALL issue afterward until new requests.

Configuration
REQ-025 Macro FB_ARBITER_CLEAR_EN defined: clear FSM per REQ-018..022 compiled in.
REQ-026 FB_ARBITER_CLEAR_EN undefined: clear logic removed, ports kept, clear_start ignored, clear_busy constant 0, FSM permanently IDLE.

Verification
REQ-027 Reset, then rd_req=1 idx 0x0010 continuously, no writes -> rd_grant=1 every cycle, rd_valid each following cycle, mem_we=0.
REQ-028 wr_req idx 0x0020 data 0xABCD, then rd_req idx 0x0020 next cycle -> drain first (mem_we=1, addr 0x0020), read granted following cycle, rd_data=0xABCD.
REQ-029 Continuous rd_req plus 3 writes (WBUF_DEPTH=2) -> wr_ready=0 after two, forced drain stalls read one cycle, all 3 writes reach memory in order.
REQ-030 INDEX_WIDTH=4, 1 buffered write, clear_start value 0x1234 -> 1 drain cycle, then 16 writes 0x0..0xF of 0x1234, clear_busy high 17 cycles, rd_grant/wr_ready 0 throughout.
REQ-031 Assert reset=0 mid-clear at address 0x7 -> mem_we=0 immediately, clear_busy=0, no further clear writes after release.
REQ-032 Build without FB_ARBITER_CLEAR_EN, pulse clear_start -> clear_busy stays 0, reads and writes unaffected.

Source files
------------

// File: rtl/framebuffer_spram_arbiter.sv
// Framebuffer single-port RAM arbiter.
// Shares one single-port RAM between a pipeline read port, a buffered pipeline
// write port and an optional whole-framebuffer clear engine.
// Optional feature: define FB_ARBITER_CLEAR_EN to compile in the clear FSM.
// Without it the clear ports stay on the interface but do nothing.
module framebuffer_spram_arbiter #(
  parameter int unsigned INDEX_WIDTH = 14,
  parameter int unsigned WBUF_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_req,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic                   rd_grant,
  output logic                   rd_valid,
  output logic [15:0]            rd_data,
  input  logic                   wr_req,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [15:0]            wr_data,
  output logic                   wr_ready,
  input  logic                   clear_start,
  input  logic [15:0]            clear_value,
  output logic                   clear_busy,
  output logic [INDEX_WIDTH-1:0] mem_addr,
  output logic [15:0]            mem_wdata,
  output logic                   mem_we,
  input  logic [15:0]            mem_rdata
);

  localparam int unsigned PtrW = $clog2(WBUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

  // Write buffer storage and bookkeeping
  logic [INDEX_WIDTH-1:0] fifo_idx_q  [WBUF_DEPTH];
  logic [15:0]            fifo_data_q [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0]  fifo_vld_q;
  logic [PtrW-1:0]        wptr_q;
  logic [PtrW-1:0]        rptr_q;
  logic [CntW-1:0]        cnt_q;

  // live_q keeps every request path closed until the first clock after reset release
  logic live_q;
  logic rd_valid_q;

  logic full;
  logic empty;
  logic hazard;
  logic do_drain;
  logic do_read;
  logic do_enq;

  // Clear engine view shared by both builds
  state_e                 state_q;
  logic                   clear_wr;
  logic [INDEX_WIDTH-1:0] clr_addr;
  logic [15:0]            clr_value_q;

  assign full  = (cnt_q == CntW'(WBUF_DEPTH));
  assign empty = (cnt_q == '0);

  // RAW hazard: read index matches any write still sitting in the buffer
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
      if (fifo_vld_q[i] && (fifo_idx_q[i] == rd_index)) hazard = 1'b1;
    end
  end

  // Per-cycle access selection
  always_comb begin
    do_drain = 1'b0;
    do_read  = 1'b0;
    if (live_q) begin
      if (state_q == StIdle) begin
        if (full)                  do_drain = 1'b1;
        else if (rd_req && hazard) do_drain = 1'b1;
        else if (rd_req)           do_read  = 1'b1;
        else if (!empty)           do_drain = 1'b1;
      end else if (state_q == StDrain) begin
        do_drain = !empty;
      end
    end
  end

  assign wr_ready   = live_q && (state_q == StIdle) && !full;
  assign do_enq     = wr_req && wr_ready;
  assign rd_grant   = do_read;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = mem_rdata;
  assign clear_busy = (state_q != StIdle);

  // RAM port mux: at most one of drain, clear write or read per cycle
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = rd_index;
    mem_wdata = '0;
    if (do_drain) begin
      mem_we    = 1'b1;
      mem_addr  = fifo_idx_q[rptr_q];
      mem_wdata = fifo_data_q[rptr_q];
    end else if (clear_wr) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = clr_value_q;
    end
  end

  // Write buffer control state and read-return pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      fifo_vld_q <= '0;
      live_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      live_q     <= 1'b1;
      rd_valid_q <= do_read;
      if (do_drain) begin
        fifo_vld_q[rptr_q] <= 1'b0;
        rptr_q             <= rptr_q + PtrW'(1);
      end
      if (do_enq) begin
        fifo_vld_q[wptr_q] <= 1'b1;
        wptr_q             <= wptr_q + PtrW'(1);
      end
      case ({do_enq, do_drain})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Write buffer payload; contents are qualified by fifo_vld_q so no reset needed
  always_ff @(posedge clk) begin
    if (do_enq) begin
      fifo_idx_q[wptr_q]  <= wr_index;
      fifo_data_q[wptr_q] <= wr_data;
    end
  end

`ifdef FB_ARBITER_CLEAR_EN
  logic [INDEX_WIDTH:0] clr_cnt_q;
  logic [INDEX_WIDTH:0] clr_cnt_nxt;

  assign clr_cnt_nxt = clr_cnt_q + (INDEX_WIDTH + 1)'(1);
  assign clear_wr    = (state_q == StClear);
  assign clr_addr    = clr_cnt_q[INDEX_WIDTH-1:0];

  // Clear FSM: flush buffered writes, then sweep every address with the latched value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      clr_cnt_q   <= '0;
      clr_value_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (live_q && clear_start) begin
            state_q     <= StDrain;
            clr_value_q <= clear_value;
          end
        end
        StDrain: begin
          // Leave as soon as the buffer is empty after this cycle's drain
          if (empty || ((cnt_q == CntW'(1)) && do_drain)) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
          end
        end
        StClear: begin
          if (clr_cnt_nxt[INDEX_WIDTH]) begin
            state_q   <= StIdle;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_nxt;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  logic unused_clear;

  assign state_q      = StIdle;
  assign clear_wr     = 1'b0;
  assign clr_addr     = '0;
  assign clr_value_q  = '0;
  assign unused_clear = ^{clear_start, clear_value};
`endif

endmodule

// File: tb/tb_framebuffer_spram_arbiter.sv
// Directed self-checking bench for framebuffer_spram_arbiter.
// Clear-engine scenarios run when FB_ARBITER_CLEAR_EN is defined; otherwise the
// bench checks that the clear ports are inert.
module tb_framebuffer_spram_arbiter;

  localparam int unsigned IW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req;
  logic [IW-1:0] rd_index;
  logic          rd_grant;
  logic          rd_valid;
  logic [15:0]   rd_data;
  logic          wr_req;
  logic [IW-1:0] wr_index;
  logic [15:0]   wr_data;
  logic          wr_ready;
  logic          clear_start;
  logic [15:0]   clear_value;
  logic          clear_busy;
  logic [IW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_we;
  logic [15:0]   mem_rdata;

  logic [15:0] mem [64];

  int checks   = 0;
  int failures = 0;

  framebuffer_spram_arbiter #(
    .INDEX_WIDTH (IW),
    .WBUF_DEPTH  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_req      (rd_req),
    .rd_index    (rd_index),
    .rd_grant    (rd_grant),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .wr_req      (wr_req),
    .wr_index    (wr_index),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .clear_start (clear_start),
    .clear_value (clear_value),
    .clear_busy  (clear_busy),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM model with one cycle read latency
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else        mem_rdata     <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
    mem_rdata   = '0;
    reset       = 1'b0;
    rd_req      = 1'b1;
    rd_index    = 6'h10;
    wr_req      = 1'b1;
    wr_index    = 6'h01;
    wr_data     = 16'h0101;
    clear_start = 1'b0;
    clear_value = '0;

    // Reset: everything quiet even with requests pending
    #2;
    chk("rst_rd_grant", 32'(rd_grant), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_clear_busy", 32'(clear_busy), 32'd0);
    step();
    step();
    reset  = 1'b1;
    wr_req = 1'b0;
    mid();
    chk("rel_rd_grant", 32'(rd_grant), 32'd0);
    chk("rel_wr_ready", 32'(wr_ready), 32'd0);
    step();

    // Continuous reads, no writes
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("rd_stream_grant", 32'(rd_grant), 32'd1);
      chk("rd_stream_we", 32'(mem_we), 32'd0);
      chk("rd_stream_addr", 32'(mem_addr), 32'h10);
      if (k > 0) begin
        chk("rd_stream_valid", 32'(rd_valid), 32'd1);
        chk("rd_stream_data", 32'(rd_data), 32'h1010);
      end
      step();
    end

    // RAW hazard: write 0x20 then read 0x20
    rd_req   = 1'b0;
    wr_req   = 1'b1;
    wr_index = 6'h20;
    wr_data  = 16'hABCD;
    mid();
    chk("raw_wr_ready", 32'(wr_ready), 32'd1);
    chk("raw_idle_we", 32'(mem_we), 32'd0);
    step();
    wr_req   = 1'b0;
    rd_req   = 1'b1;
    rd_index = 6'h20;
    mid();
    chk("raw_drain_we", 32'(mem_we), 32'd1);
    chk("raw_drain_addr", 32'(mem_addr), 32'h20);
    chk("raw_drain_data", 32'(mem_wdata), 32'hABCD);
    chk("raw_drain_grant", 32'(rd_grant), 32'd0);
    step();
    mid();
    chk("raw_read_grant", 32'(rd_grant), 32'd1);
    chk("raw_read_we", 32'(mem_we), 32'd0);
    step();
    rd_req = 1'b0;
    mid();
    chk("raw_rd_valid", 32'(rd_valid), 32'd1);
    chk("raw_rd_data", 32'(rd_data), 32'hABCD);
    step();

    // Same-cycle read and write to one index returns old data
    rd_req   = 1'b1;
    rd_index = 6'h05;
    wr_req   = 1'b1;
    wr_index = 6'h05;
    wr_data  = 16'h5555;
    mid();
    chk("same_grant", 32'(rd_grant), 32'd1);
    chk("same_wr_ready", 32'(wr_ready), 32'd1);
    step();
    rd_req = 1'b0;
    wr_req = 1'b0;
    mid();
    chk("same_drain_we", 32'(mem_we), 32'd1);
    chk("same_drain_addr", 32'(mem_addr), 32'h05);
    chk("same_rd_valid", 32'(rd_valid), 32'd1);
    chk("same_rd_data", 32'(rd_data), 32'h1005);
    step();

    // Three writes under continuous reads with a two-entry buffer
    rd_req   = 1'b1;
    rd_index = 6'h10;
    wr_req   = 1'b1;
    wr_index = 6'h30;
    wr_data  = 16'hD001;
    mid();
    chk("w3_c0_grant", 32'(rd_grant), 32'd1);
    chk("w3_c0_ready", 32'(wr_ready), 32'd1);
    step();
    wr_index = 6'h31;
    wr_data  = 16'hD002;
    mid();
    chk("w3_c1_grant", 32'(rd_grant), 32'd1);
    chk("w3_c1_ready", 32'(wr_ready), 32'd1);
    step();
    wr_index = 6'h32;
    wr_data  = 16'hD003;
    mid();
    chk("w3_c2_ready", 32'(wr_ready), 32'd0);
    chk("w3_c2_grant", 32'(rd_grant), 32'd0);
    chk("w3_c2_we", 32'(mem_we), 32'd1);
    chk("w3_c2_addr", 32'(mem_addr), 32'h30);
    chk("w3_c2_data", 32'(mem_wdata), 32'hD001);
    step();
    mid();
    chk("w3_c3_ready", 32'(wr_ready), 32'd1);
    chk("w3_c3_grant", 32'(rd_grant), 32'd1);
    chk("w3_c3_we", 32'(mem_we), 32'd0);
    chk("w3_c3_valid", 32'(rd_valid), 32'd0);
    step();
    wr_req = 1'b0;
    mid();
    chk("w3_c4_ready", 32'(wr_ready), 32'd0);
    chk("w3_c4_grant", 32'(rd_grant), 32'd0);
    chk("w3_c4_addr", 32'(mem_addr), 32'h31);
    chk("w3_c4_data", 32'(mem_wdata), 32'hD002);
    step();
    mid();
    chk("w3_c5_grant", 32'(rd_grant), 32'd1);
    chk("w3_c5_we", 32'(mem_we), 32'd0);
    step();
    rd_req = 1'b0;
    mid();
    chk("w3_c6_we", 32'(mem_we), 32'd1);
    chk("w3_c6_addr", 32'(mem_addr), 32'h32);
    chk("w3_c6_data", 32'(mem_wdata), 32'hD003);
    step();
    mid();
    chk("w3_c7_we", 32'(mem_we), 32'd0);
    chk("w3_mem30", 32'(mem[6'h30]), 32'hD001);
    chk("w3_mem31", 32'(mem[6'h31]), 32'hD002);
    chk("w3_mem32", 32'(mem[6'h32]), 32'hD003);
    step();

`ifdef FB_ARBITER_CLEAR_EN
    // Clear with one write accepted in the start cycle
    wr_req      = 1'b1;
    wr_index    = 6'h07;
    wr_data     = 16'h7777;
    clear_start = 1'b1;
    clear_value = 16'h1234;
    mid();
    chk("clr_start_ready", 32'(wr_ready), 32'd1);
    chk("clr_start_busy", 32'(clear_busy), 32'd0);
    step();
    wr_req      = 1'b0;
    clear_start = 1'b0;
    clear_value = 16'h0000;
    rd_req      = 1'b1;
    rd_index    = 6'h10;
    mid();
    chk("clr_drain_busy", 32'(clear_busy), 32'd1);
    chk("clr_drain_we", 32'(mem_we), 32'd1);
    chk("clr_drain_addr", 32'(mem_addr), 32'h07);
    chk("clr_drain_data", 32'(mem_wdata), 32'h7777);
    chk("clr_drain_grant", 32'(rd_grant), 32'd0);
    chk("clr_drain_ready", 32'(wr_ready), 32'd0);
    step();
    for (int i = 0; i < 64; i++) begin
      // A start pulse mid-clear must be ignored
      clear_start = (i == 10);
      clear_value = (i == 10) ? 16'hFFFF : 16'h0000;
      mid();
      chk("clr_busy", 32'(clear_busy), 32'd1);
      chk("clr_we", 32'(mem_we), 32'd1);
      chk("clr_addr", 32'(mem_addr), 32'(i));
      chk("clr_data", 32'(mem_wdata), 32'h1234);
      chk("clr_grant", 32'(rd_grant), 32'd0);
      chk("clr_ready", 32'(wr_ready), 32'd0);
      step();
    end
    clear_start = 1'b0;
    mid();
    chk("clr_done_busy", 32'(clear_busy), 32'd0);
    chk("clr_done_grant", 32'(rd_grant), 32'd1);
    chk("clr_done_we", 32'(mem_we), 32'd0);
    chk("clr_mem07", 32'(mem[6'h07]), 32'h1234);
    chk("clr_mem3f", 32'(mem[6'h3F]), 32'h1234);
    step();

    // Reset in the middle of a clear sweep
    rd_req      = 1'b0;
    clear_start = 1'b1;
    clear_value = 16'hBEEF;
    mid();
    chk("clr2_start_busy", 32'(clear_busy), 32'd0);
    step();
    clear_start = 1'b0;
    mid();
    chk("clr2_drain_busy", 32'(clear_busy), 32'd1);
    chk("clr2_drain_we", 32'(mem_we), 32'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      mid();
      chk("clr2_addr", 32'(mem_addr), 32'(i));
      chk("clr2_data", 32'(mem_wdata), 32'hBEEF);
      if (i < 7) step();
    end
    reset = 1'b0;
    #1;
    chk("clr2_rst_we", 32'(mem_we), 32'd0);
    chk("clr2_rst_busy", 32'(clear_busy), 32'd0);
    step();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("clr2_after_we", 32'(mem_we), 32'd0);
      chk("clr2_after_busy", 32'(clear_busy), 32'd0);
      step();
    end
    chk("clr2_mem06", 32'(mem[6'h06]), 32'hBEEF);
    chk("clr2_mem07", 32'(mem[6'h07]), 32'h1234);
`else
    // Clear ports inert without the clear engine
    clear_start = 1'b1;
    clear_value = 16'h4321;
    rd_req      = 1'b1;
    rd_index    = 6'h10;
    wr_req      = 1'b1;
    wr_index    = 6'h11;
    wr_data     = 16'h1111;
    mid();
    chk("noclr_busy0", 32'(clear_busy), 32'd0);
    chk("noclr_grant", 32'(rd_grant), 32'd1);
    chk("noclr_ready", 32'(wr_ready), 32'd1);
    step();
    clear_start = 1'b0;
    rd_req      = 1'b0;
    wr_req      = 1'b0;
    mid();
    chk("noclr_busy1", 32'(clear_busy), 32'd0);
    chk("noclr_drain_we", 32'(mem_we), 32'd1);
    chk("noclr_drain_addr", 32'(mem_addr), 32'h11);
    chk("noclr_drain_data", 32'(mem_wdata), 32'h1111);
    chk("noclr_rd_valid", 32'(rd_valid), 32'd1);
    chk("noclr_rd_data", 32'(rd_data), 32'h1010);
    step();
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("noclr_busy_hold", 32'(clear_busy), 32'd0);
      chk("noclr_idle_we", 32'(mem_we), 32'd0);
      step();
    end
`endif

    // Reset discards a buffered write
    rd_req   = 1'b1;
    rd_index = 6'h10;
    wr_req   = 1'b1;
    wr_index = 6'h3A;
    wr_data  = 16'hDEAD;
    mid();
    chk("flush_grant0", 32'(rd_grant), 32'd1);
    chk("flush_ready", 32'(wr_ready), 32'd1);
    step();
    wr_req = 1'b0;
    mid();
    chk("flush_grant1", 32'(rd_grant), 32'd1);
    chk("flush_we_held", 32'(mem_we), 32'd0);
    reset = 1'b0;
    #1;
    chk("flush_rst_we", 32'(mem_we), 32'd0);
    step();
    reset  = 1'b1;
    rd_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("flush_after_we", 32'(mem_we), 32'd0);
      step();
    end
    chk("flush_mem3a", 32'(mem[6'h3A]), 32'h103A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
